// File: rtl/dmem_arb_pkg.sv
// Shared types and constants for the data-memory arbiter.
package dmem_arb_pkg;

    localparam int DMEM_DEPTH = 1024;
    localparam int ADDR_W     = 32;
    localparam int DATA_W     = 32;

    // Identifies a memory requester.
    typedef enum logic {
        REQ_CPU  = 1'b0,
        REQ_UART = 1'b1
    } req_id_t;

    // One memory transaction as presented by a requester.
    typedef struct packed {
        logic              we;
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] wdata;
    } mem_req_t;

endpackage

// File: rtl/rr_arbiter2.sv
// Two-way round-robin arbiter. It grants the CPU or the UART engine, and it
// holds a pointer to the requester granted most recently.
module rr_arbiter2
    import dmem_arb_pkg::*;
(
    input  logic clk,
    input  logic rst,
    input  logic cpu_req,
    input  logic uart_req,
    output logic cpu_gnt,
    output logic uart_gnt
);

    req_id_t last;
    req_id_t last_next;

    // Pointer register. After reset it points at the UART, so the CPU wins
    // the first contested cycle.
    // NOTE: use <= for state so that every register updates from values
    // taken before the clock edge.
    always_ff @(posedge clk) begin
        if (rst) last <= REQ_UART;
        else     last <= last_next;
    end

    // Grant selection. When both requesters are active, the one not granted
    // last time wins. No grant is issued while reset is high.
    // NOTE: each output gets a default first, so every path assigns it and
    // no latch is inferred.
    always_comb begin
        cpu_gnt   = 1'b0;
        uart_gnt  = 1'b0;
        last_next = last;
        if (!rst) begin
            if (cpu_req && uart_req) begin
                if (last == REQ_UART) cpu_gnt  = 1'b1;
                else                  uart_gnt = 1'b1;
            end else if (cpu_req) begin
                cpu_gnt = 1'b1;
            end else if (uart_req) begin
                uart_gnt = 1'b1;
            end
        end
        if (cpu_gnt)       last_next = REQ_CPU;
        else if (uart_gnt) last_next = REQ_UART;
    end

endmodule

// File: rtl/dmem_arbiter.sv
// Shares the single data memory between the CPU LSU and the UART buffer
// engine. It contains the memory-port mux, the address range check and the
// registered responses, which arrive one cycle after each grant.
module dmem_arbiter
    import dmem_arb_pkg::*;
#(
    parameter int DEPTH = DMEM_DEPTH,
    parameter int AW    = ADDR_W
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          cpu_req,
    input  logic          cpu_we,
    input  logic [AW-1:0] cpu_addr,
    input  logic [31:0]   cpu_wdata,
    input  logic          uart_req,
    input  logic          uart_we,
    input  logic [AW-1:0] uart_addr,
    input  logic [31:0]   uart_wdata,
    output logic          cpu_gnt,
    output logic          uart_gnt,
    output logic          cpu_rvalid,
    output logic [31:0]   cpu_rdata,
    output logic          cpu_err,
    output logic          uart_rvalid,
    output logic [31:0]   uart_rdata,
    output logic          uart_err,
    output logic          mem_sel,
    output logic          mem_we,
    output logic [31:0]   mem_addr,
    output logic [31:0]   mem_wd,
    input  logic [31:0]   mem_rd
);

    mem_req_t    cpu_txn, uart_txn, sel_txn;
    logic        cpu_ok, uart_ok, sel_ok;
    logic        cpu_rvalid_q, uart_rvalid_q, cpu_err_q, uart_err_q;
    logic [31:0] cpu_rdata_q, uart_rdata_q;

    rr_arbiter2 u_arb (
        .clk      (clk),
        .rst      (rst),
        .cpu_req  (cpu_req),
        .uart_req (uart_req),
        .cpu_gnt  (cpu_gnt),
        .uart_gnt (uart_gnt)
    );

    // The range check uses the full requester address width and is unsigned,
    // so addr == DEPTH and any high bits count as out of range.
    assign cpu_ok   = cpu_addr  < AW'(DEPTH);
    assign uart_ok  = uart_addr < AW'(DEPTH);
    assign cpu_txn  = '{we: cpu_we,  addr: ADDR_W'(cpu_addr),  wdata: cpu_wdata};
    assign uart_txn = '{we: uart_we, addr: ADDR_W'(uart_addr), wdata: uart_wdata};

    // Memory-port mux. The granted requester drives the port. An out-of-range
    // grant leaves the memory deselected, and an idle port is driven to zero.
    always_comb begin
        sel_txn = '0;
        sel_ok  = 1'b0;
        if (cpu_gnt) begin
            sel_txn = cpu_txn;
            sel_ok  = cpu_ok;
        end else if (uart_gnt) begin
            sel_txn = uart_txn;
            sel_ok  = uart_ok;
        end
        mem_sel  = (cpu_gnt | uart_gnt) & sel_ok;
        mem_we   = mem_sel & sel_txn.we;
        mem_addr = sel_txn.addr;
        mem_wd   = sel_txn.wdata;
    end

    // Response registers: one pulse per grant. The data is captured only for
    // in-range reads, and the error flag is set for out-of-range grants.
    always_ff @(posedge clk) begin
        if (rst) begin
            cpu_rvalid_q  <= 1'b0;
            cpu_err_q     <= 1'b0;
            cpu_rdata_q   <= '0;
            uart_rvalid_q <= 1'b0;
            uart_err_q    <= 1'b0;
            uart_rdata_q  <= '0;
        end else begin
            cpu_rvalid_q  <= cpu_gnt;
            cpu_err_q     <= cpu_gnt & ~cpu_ok;
            cpu_rdata_q   <= (cpu_gnt & cpu_ok & ~cpu_we) ? mem_rd : '0;
            uart_rvalid_q <= uart_gnt;
            uart_err_q    <= uart_gnt & ~uart_ok;
            uart_rdata_q  <= (uart_gnt & uart_ok & ~uart_we) ? mem_rd : '0;
        end
    end

    // A reset that arrives in the response cycle discards that response.
    assign cpu_rvalid  = rst ? 1'b0 : cpu_rvalid_q;
    assign cpu_err     = rst ? 1'b0 : cpu_err_q;
    assign cpu_rdata   = rst ? '0   : cpu_rdata_q;
    assign uart_rvalid = rst ? 1'b0 : uart_rvalid_q;
    assign uart_err    = rst ? 1'b0 : uart_err_q;
    assign uart_rdata  = rst ? '0   : uart_rdata_q;

endmodule
